// File: rtl/uart_cmd_responder_pkg.sv
// Shared opcodes, response codes and FSM encoding
// for the UART command responder.
package uart_cmd_responder_pkg;

   localparam logic [7:0] OP_WR   = 8'h57;
   localparam logic [7:0] OP_RD   = 8'h52;
   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CAP_OP  = 3'd1,
      S_GET_ARG = 3'd2,
      S_CAP_ARG = 3'd3,
      S_BUS     = 3'd4,
      S_SEND    = 3'd5
   } state_t;

endpackage

// File: rtl/uart_cmd_responder_if.sv
// RX FIFO read side, TX FIFO write side and register
// bus between the responder and its surroundings.
interface uart_cmd_responder_if;

   logic       rx_empty;
   logic       rx_rden;
   logic [7:0] rx_data;
   logic       tx_full;
   logic       tx_wren;
   logic [7:0] tx_data;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       reg_ack;

   modport master (
      input  rx_empty, rx_data, tx_full,
      input  reg_rdata, reg_ack,
      output rx_rden, tx_wren, tx_data,
      output reg_wr, reg_rd, reg_addr, reg_wdata
   );

   modport slave (
      output rx_empty, rx_data, tx_full,
      output reg_rdata, reg_ack,
      input  rx_rden, tx_wren, tx_data,
      input  reg_wr, reg_rd, reg_addr, reg_wdata
   );

endinterface

// File: rtl/uart_cmd_responder.sv
// Byte command responder: pops W/R requests from the RX
// FIFO, runs one register bus cycle, pushes one reply.
module uart_cmd_responder
   import uart_cmd_responder_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int          CNT_WIDTH      = 16
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   uart_cmd_responder_if.master bus,
   output logic                 busy,
   output logic [7:0]           err_count
);

   localparam logic [CNT_WIDTH-1:0] C_TLAST =
      CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t               r_state;
   state_t               w_next;
   logic [CNT_WIDTH-1:0] r_timer;
   logic                 r_is_wr;
   logic                 r_argi;
   logic [7:0]           r_addr;
   logic [7:0]           r_wdata;
   logic [7:0]           r_resp;
   logic [7:0]           r_err;
   logic                 w_rden;
   logic                 w_wren;
   logic                 w_nak;
   logic                 w_tmo;
   logic                 w_op_ok;

   assign w_tmo   = (r_timer == C_TLAST);
   assign w_op_ok = (bus.rx_data == OP_WR) ||
                    (bus.rx_data == OP_RD);

   always_comb begin
      w_next = r_state;
      w_rden = 1'b0;
      w_wren = 1'b0;
      w_nak  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (enable && !bus.rx_empty) begin
               w_rden = 1'b1;
               w_next = S_CAP_OP;
            end
         end
         S_CAP_OP: begin
            if (w_op_ok) begin
               w_next = S_GET_ARG;
            end else begin
               w_nak  = 1'b1;
               w_next = S_SEND;
            end
         end
         S_GET_ARG: begin
            if (!bus.rx_empty) begin
               w_rden = 1'b1;
               w_next = S_CAP_ARG;
            end else if (w_tmo) begin
               w_nak  = 1'b1;
               w_next = S_SEND;
            end
         end
         S_CAP_ARG: begin
            w_next = (r_is_wr && !r_argi) ? S_GET_ARG : S_BUS;
         end
         S_BUS: begin
            if (bus.reg_ack) begin
               w_next = S_SEND;
            end else if (w_tmo) begin
               w_nak  = 1'b1;
               w_next = S_SEND;
            end
         end
         S_SEND: begin
            if (!bus.tx_full) begin
               w_wren = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_timer <= '0;
         r_is_wr <= 1'b0;
         r_argi  <= 1'b0;
         r_addr  <= 8'h00;
         r_wdata <= 8'h00;
         r_resp  <= 8'h00;
         r_err   <= 8'h00;
      end else begin
         r_state <= w_next;
         // timer restarts on every state change
         if (w_next != r_state) begin
            r_timer <= '0;
         end else if (r_state == S_GET_ARG ||
                      r_state == S_BUS) begin
            r_timer <= r_timer + CNT_WIDTH'(1);
         end
         if (r_state == S_CAP_OP) begin
            r_is_wr <= (bus.rx_data == OP_WR);
            r_argi  <= 1'b0;
         end
         if (r_state == S_CAP_ARG) begin
            if (!r_argi) r_addr <= bus.rx_data;
            else         r_wdata <= bus.rx_data;
            r_argi <= 1'b1;
         end
         if (w_nak) begin
            r_resp <= RSP_NAK;
         end else if (r_state == S_BUS && bus.reg_ack) begin
            r_resp <= r_is_wr ? RSP_ACK : bus.reg_rdata;
         end
         if (w_nak && r_err != 8'hFF) begin
            r_err <= r_err + 8'd1;
         end
      end
   end

   assign bus.rx_rden   = w_rden;
   assign bus.tx_wren   = w_wren;
   assign bus.tx_data   = r_resp;
   assign bus.reg_wr    = (r_state == S_BUS) && r_is_wr;
   assign bus.reg_rd    = (r_state == S_BUS) && !r_is_wr;
   assign bus.reg_addr  = r_addr;
   assign bus.reg_wdata = r_wdata;
   assign busy          = (r_state != S_IDLE);
   assign err_count     = r_err;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench: FIFO and register-bus models around
// the responder, one task per scenario.
module tb_uart_cmd_responder;

   logic       clock;
   logic       reset_n;
   logic       enable;
   logic       busy;
   logic [7:0] err_count;

   uart_cmd_responder_if ifc();

   uart_cmd_responder #(
      .TIMEOUT_CYCLES(8),
      .CNT_WIDTH(16)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .enable(enable),
      .bus(ifc),
      .busy(busy),
      .err_count(err_count)
   );

   int n_chk;
   int n_fail;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // RX FIFO model: data appears the cycle after rx_rden
   logic [7:0] rx_mem [256];
   logic [7:0] rx_wp;
   logic [7:0] rx_rp;

   assign ifc.rx_empty = (rx_wp == rx_rp);

   always @(posedge clock) begin
      if (ifc.rx_rden && (rx_wp != rx_rp)) begin
         ifc.rx_data <= rx_mem[rx_rp];
         rx_rp       <= rx_rp + 8'd1;
      end
   end

   // register bus model: ack after ack_dly+1 strobe cycles
   int ack_dly;
   bit ack_en;
   int scnt;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ifc.reg_ack <= 1'b0;
         scnt        <= 0;
      end else begin
         ifc.reg_ack <= 1'b0;
         if ((ifc.reg_wr || ifc.reg_rd) && !ifc.reg_ack
             && ack_en) begin
            if (scnt == ack_dly) begin
               ifc.reg_ack <= 1'b1;
               scnt        <= 0;
            end else begin
               scnt <= scnt + 1;
            end
         end else begin
            scnt <= 0;
         end
      end
   end

   task automatic push(input logic [7:0] b);
      rx_mem[rx_wp] = b;
      rx_wp = rx_wp + 8'd1;
   endtask

   task automatic drive_slot();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      drive_slot();
      reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // observation results, cycle 0 = first negedge after call
   int         t_rden0, n_rden, t_wr, t_rd, t_ack, t_wren;
   int         n_wr_cyc, viol;
   logic [7:0] ob_addr, ob_wdata, ob_tx;

   task automatic observe(input int lim);
      logic prev_rden;
      t_rden0  = -1; n_rden = 0; t_wr = -1; t_rd = -1;
      t_ack    = -1; t_wren = -1; n_wr_cyc = 0;
      prev_rden = 1'b0;
      for (int c = 0; c < lim; c++) begin
         @(negedge clock);
         if (ifc.rx_rden) begin
            if (ifc.rx_empty || prev_rden) viol++;
            if (t_rden0 < 0) t_rden0 = c;
            n_rden++;
         end
         prev_rden = ifc.rx_rden;
         if (ifc.reg_wr) begin
            n_wr_cyc++;
            if (t_wr < 0) begin
               t_wr     = c;
               ob_addr  = ifc.reg_addr;
               ob_wdata = ifc.reg_wdata;
            end
         end
         if (ifc.reg_rd && t_rd < 0) begin
            t_rd    = c;
            ob_addr = ifc.reg_addr;
         end
         if (ifc.reg_ack && t_ack < 0) t_ack = c;
         if (ifc.tx_wren) begin
            if (ifc.tx_full) viol++;
            t_wren = c;
            ob_tx  = ifc.tx_data;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clock);
      n_chk++;
      if (busy !== 1'b0 || err_count !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_state busy=%b err=%h want 0/00",
                  busy, err_count);
      end
      n_chk++;
      if ({ifc.rx_rden, ifc.tx_wren, ifc.reg_wr, ifc.reg_rd}
          !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_strobes got %b want 0000",
                  {ifc.rx_rden, ifc.tx_wren,
                   ifc.reg_wr, ifc.reg_rd});
      end
      n_chk++;
      if ({ifc.reg_addr, ifc.reg_wdata, ifc.tx_data}
          !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_data got %h want 000000",
                  {ifc.reg_addr, ifc.reg_wdata, ifc.tx_data});
      end
   endtask

   task automatic test_write();
      ack_dly = 1;
      drive_slot();
      push(8'h57); push(8'h10); push(8'hA5);
      observe(40);
      n_chk++;
      if (t_rden0 !== 0 || t_wr !== 6) begin
         n_fail++;
         $display("FAIL wr_latency rden@%0d wr@%0d want 0/6",
                  t_rden0, t_wr);
      end
      n_chk++;
      if (ob_addr !== 8'h10 || ob_wdata !== 8'hA5) begin
         n_fail++;
         $display("FAIL wr_bus addr=%h data=%h want 10/A5",
                  ob_addr, ob_wdata);
      end
      n_chk++;
      if (t_ack !== 8 || n_wr_cyc !== 3) begin
         n_fail++;
         $display("FAIL wr_hold ack@%0d wr_cycles=%0d want 8/3",
                  t_ack, n_wr_cyc);
      end
      n_chk++;
      if (t_wren < 0 || ob_tx !== 8'h06 || t_rd !== -1) begin
         n_fail++;
         $display("FAIL wr_resp tx=%h wren@%0d rd@%0d want 06",
                  ob_tx, t_wren, t_rd);
      end
      n_chk++;
      if (err_count !== 8'h00 || n_rden !== 3) begin
         n_fail++;
         $display("FAIL wr_misc err=%h rden=%0d want 00/3",
                  err_count, n_rden);
      end
   endtask

   task automatic test_read();
      ack_dly = 0;
      ifc.reg_rdata = 8'hC7;
      drive_slot();
      push(8'h52); push(8'h3C);
      observe(40);
      n_chk++;
      if (t_rd !== 4 || ob_addr !== 8'h3C) begin
         n_fail++;
         $display("FAIL rd_bus rd@%0d addr=%h want 4/3C",
                  t_rd, ob_addr);
      end
      n_chk++;
      if (t_wren < 0 || ob_tx !== 8'hC7) begin
         n_fail++;
         $display("FAIL rd_resp tx=%h wren@%0d want C7",
                  ob_tx, t_wren);
      end
      n_chk++;
      if (n_rden !== 2 || t_wr !== -1) begin
         n_fail++;
         $display("FAIL rd_rden count=%0d wr@%0d want 2/-1",
                  n_rden, t_wr);
      end
      ack_dly = 1;
   endtask

   task automatic test_bad_opcode();
      ifc.reg_rdata = 8'h5A;
      drive_slot();
      push(8'h41); push(8'h52); push(8'h01);
      observe(40);
      n_chk++;
      if (t_wren !== 2 || ob_tx !== 8'h15 || n_rden !== 1) begin
         n_fail++;
         $display("FAIL bad_nak tx=%h wren@%0d rden=%0d want 15/2/1",
                  ob_tx, t_wren, n_rden);
      end
      n_chk++;
      if (err_count !== 8'h01) begin
         n_fail++;
         $display("FAIL bad_err err=%h want 01", err_count);
      end
      observe(40);
      n_chk++;
      if (t_rden0 !== 0 || t_rd !== 4 || ob_addr !== 8'h01) begin
         n_fail++;
         $display("FAIL bad_next rden@%0d rd@%0d addr=%h want 0/4/01",
                  t_rden0, t_rd, ob_addr);
      end
      n_chk++;
      if (ob_tx !== 8'h5A || err_count !== 8'h01) begin
         n_fail++;
         $display("FAIL bad_next_resp tx=%h err=%h want 5A/01",
                  ob_tx, err_count);
      end
   endtask

   task automatic test_enable();
      ifc.reg_rdata = 8'h3E;
      drive_slot();
      enable = 1'b0;
      push(8'h52); push(8'h07);
      observe(5);
      n_chk++;
      if (n_rden !== 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL en_gate rden=%0d busy=%b want 0/0",
                  n_rden, busy);
      end
      drive_slot();
      enable = 1'b1;
      observe(40);
      n_chk++;
      if (t_rden0 !== 0 || ob_tx !== 8'h3E || ob_addr !== 8'h07) begin
         n_fail++;
         $display("FAIL en_resume rden@%0d tx=%h addr=%h want 0/3E/07",
                  t_rden0, ob_tx, ob_addr);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      push(8'h57); push(8'h20);
      observe(40);
      n_chk++;
      if (t_wren !== 12 || ob_tx !== 8'h15) begin
         n_fail++;
         $display("FAIL tmo_nak wren@%0d tx=%h want 12/15",
                  t_wren, ob_tx);
      end
      n_chk++;
      if (t_wr !== -1 || err_count !== 8'h01 || n_rden !== 2) begin
         n_fail++;
         $display("FAIL tmo_misc wr@%0d err=%h rden=%0d want -1/01/2",
                  t_wr, err_count, n_rden);
      end
   endtask

   task automatic test_backpressure();
      ifc.reg_rdata = 8'h99;
      drive_slot();
      ifc.tx_full = 1'b1;
      push(8'h52); push(8'h3C);
      observe(20);
      n_chk++;
      if (t_wren !== -1 || busy !== 1'b1 || t_ack < 0) begin
         n_fail++;
         $display("FAIL bp_hold wren@%0d busy=%b ack@%0d want -1/1",
                  t_wren, busy, t_ack);
      end
      drive_slot();
      ifc.tx_full = 1'b0;
      observe(5);
      n_chk++;
      if (t_wren !== 0 || ob_tx !== 8'h99) begin
         n_fail++;
         $display("FAIL bp_release wren@%0d tx=%h want 0/99",
                  t_wren, ob_tx);
      end
   endtask

   task automatic test_reset_mid_bus();
      ack_en = 1'b0;
      drive_slot();
      push(8'h52); push(8'h3C);
      observe(6);
      n_chk++;
      if (t_rd !== 4 || ifc.reg_rd !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre rd@%0d reg_rd=%b want 4/1",
                  t_rd, ifc.reg_rd);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_chk++;
      if ({ifc.reg_rd, ifc.reg_wr, ifc.tx_wren, ifc.rx_rden, busy}
          !== 5'b0 || ifc.reg_addr !== 8'h00
          || err_count !== 8'h00) begin
         n_fail++;
         $display("FAIL rst_async rd=%b busy=%b addr=%h err=%h want 0",
                  ifc.reg_rd, busy, ifc.reg_addr, err_count);
      end
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      ack_en  = 1'b1;
      observe(12);
      n_chk++;
      if (t_wren !== -1 || n_rden !== 0) begin
         n_fail++;
         $display("FAIL rst_quiet wren@%0d rden=%0d want -1/0",
                  t_wren, n_rden);
      end
      drive_slot();
      push(8'h57); push(8'h11); push(8'h22);
      observe(40);
      n_chk++;
      if (ob_tx !== 8'h06 || ob_addr !== 8'h11
          || ob_wdata !== 8'h22) begin
         n_fail++;
         $display("FAIL rst_next tx=%h addr=%h data=%h want 06/11/22",
                  ob_tx, ob_addr, ob_wdata);
      end
   endtask

   task automatic test_err_saturate();
      do_reset();
      for (int i = 0; i < 254; i++) begin
         drive_slot();
         push(8'h41);
         observe(10);
      end
      n_chk++;
      if (err_count !== 8'hFE) begin
         n_fail++;
         $display("FAIL sat_fe err=%h want FE", err_count);
      end
      for (int i = 0; i < 2; i++) begin
         drive_slot();
         push(8'h41);
         observe(10);
         n_chk++;
         if (err_count !== 8'hFF || ob_tx !== 8'h15) begin
            n_fail++;
            $display("FAIL sat_ff err=%h tx=%h want FF/15",
                     err_count, ob_tx);
         end
      end
   endtask

   initial begin
      reset_n       = 1'b0;
      enable        = 1'b1;
      ifc.tx_full   = 1'b0;
      ifc.reg_rdata = 8'h00;
      rx_wp         = 8'h00;
      rx_rp         = 8'h00;
      ack_dly       = 1;
      ack_en        = 1'b1;
      viol          = 0;
      n_chk         = 0;
      n_fail        = 0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      test_reset();
      test_write();
      test_read();
      test_bad_opcode();
      test_enable();
      test_timeout();
      test_backpressure();
      test_reset_mid_bus();
      test_err_saturate();
      n_chk++;
      if (viol !== 0) begin
         n_fail++;
         $display("FAIL protocol_rules violations=%0d want 0", viol);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
